// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module : rv32i_pkg
// Brief  : Shared RV32I opcodes, bubble word and immediate-format helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] NOP_IW = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
        imm_fmt_e fmt;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] iw, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{21{iw[31]}}, iw[30:20]};
            IMM_S:   imm = {{21{iw[31]}}, iw[30:25], iw[11:7]};
            IMM_B:   imm = {{20{iw[31]}}, iw[7], iw[30:25], iw[11:8], 1'b0};
            IMM_U:   imm = {iw[31:12], 12'b0};
            IMM_J:   imm = {{12{iw[31]}}, iw[19:12], iw[20], iw[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        logic w;
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w = 1'b1;
            default:                                                   w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_regFile.sv
// ============================================================================
// Module : rv32i_regFile
// Brief  : 32x32 register file, two async read ports, one sync write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32i_regFile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] mem_q [32];

    // Entry 0 is only ever cleared, so x0 also reads as zero from the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : mem_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/rv32i_idtop.sv
// ============================================================================
// Module : rv32i_idtop
// Brief  : RV32I decode stage: regfile read + bypass, imm gen, ID/EX register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32i_idtop #(
    parameter logic [31:0] NOP_IW = rv32i_pkg::NOP_IW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iw_in,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_enable,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rs1_reg,
    output logic [4:0]  rs2_reg,
    output logic [4:0]  rd_reg,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm_out,
    output logic        wb_enable_out
);

    import rv32i_pkg::*;

    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [31:0] rf_rd1, rf_rd2;
    logic [31:0] rs1_data_d, rs2_data_d, imm_d;
    logic        wbe_d;

    logic [31:0] iw_q, pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic        wbe_q;

    assign rs1_d = iw_in[19:15];
    assign rs2_d = iw_in[24:20];
    assign rd_d  = iw_in[11:7];

    rv32i_regFile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_enable),
        .waddr_i  (wb_reg),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_d),
        .raddr2_i (rs2_d),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

    // A write landing on the same edge must reach the captured operand.
    assign rs1_data_d = (wb_enable && (wb_reg == rs1_d) && (rs1_d != 5'd0)) ? wb_data : rf_rd1;
    assign rs2_data_d = (wb_enable && (wb_reg == rs2_d) && (rs2_d != 5'd0)) ? wb_data : rf_rd2;

    assign imm_d = imm_gen(iw_in, imm_fmt_of(iw_in[6:0]));
    assign wbe_d = writes_rd(iw_in[6:0]) && (rd_d != 5'd0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            iw_q       <= NOP_IW;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            wbe_q      <= 1'b0;
        end else if (!stall) begin
            iw_q       <= iw_in;
            pc_q       <= pc_in;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            wbe_q      <= wbe_d;
        end
    end

    assign iw_out        = iw_q;
    assign pc_out        = pc_q;
    assign rs1_reg       = rs1_q;
    assign rs2_reg       = rs2_q;
    assign rd_reg        = rd_q;
    assign rs1_data      = rs1_data_q;
    assign rs2_data      = rs2_data_q;
    assign imm_out       = imm_q;
    assign wb_enable_out = wbe_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_idtop.sv
// ============================================================================
// Module : tb_rv32i_idtop
// Brief  : Directed vector bench for the RV32I decode stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv32i_idtop;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iw_in, pc_in;
    logic        stall, flush;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] iw_out, pc_out;
    logic [4:0]  rs1_reg, rs2_reg, rd_reg;
    logic [31:0] rs1_data, rs2_data, imm_out;
    logic        wb_enable_out;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    rv32i_idtop dut (
        .clk           (clk),
        .reset         (reset),
        .iw_in         (iw_in),
        .pc_in         (pc_in),
        .stall         (stall),
        .flush         (flush),
        .wb_enable     (wb_enable),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .iw_out        (iw_out),
        .pc_out        (pc_out),
        .rs1_reg       (rs1_reg),
        .rs2_reg       (rs2_reg),
        .rd_reg        (rd_reg),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm_out       (imm_out),
        .wb_enable_out (wb_enable_out)
    );

    typedef struct {
        logic [31:0] iw;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] imm;
        logic        wbe;
        logic [4:0]  rd;
        logic [31:0] r1;
        logic [31:0] r2;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        wb_enable = 1'b0; wb_reg = '0; wb_data = '0;
    endtask

    task automatic chk_bubble(input string nm);
        chk({nm, ".iw"},   iw_out, 32'h00000013);
        chk({nm, ".pc"},   pc_out, 32'h0);
        chk({nm, ".rs1r"}, {27'd0, rs1_reg}, 32'h0);
        chk({nm, ".rs2r"}, {27'd0, rs2_reg}, 32'h0);
        chk({nm, ".rd"},   {27'd0, rd_reg}, 32'h0);
        chk({nm, ".rs1d"}, rs1_data, 32'h0);
        chk({nm, ".rs2d"}, rs2_data, 32'h0);
        chk({nm, ".imm"},  imm_out, 32'h0);
        chk({nm, ".wbe"},  {31'd0, wb_enable_out}, 32'h0);
    endtask

    initial begin
        //          iw            pc           we  wreg  wdata         imm           wbe rd  r1            r2
        vecs[0]  = '{32'h00528133, 32'h00000100, 1, 5'd5, 32'hDEADBEEF, 32'h00000000, 1, 2,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{32'hFFF00093, 32'h00000104, 0, 5'd0, 32'h0,        32'hFFFFFFFF, 1, 1,  32'h0,        32'h0};
        vecs[2]  = '{32'hFE000EE3, 32'h00000108, 0, 5'd0, 32'h0,        32'hFFFFFFFC, 0, 29, 32'h0,        32'h0};
        vecs[3]  = '{32'h123450B7, 32'h0000010C, 0, 5'd0, 32'h0,        32'h12345000, 1, 1,  32'h0,        32'h0};
        vecs[4]  = '{32'h00028333, 32'h00000110, 0, 5'd0, 32'h0,        32'h00000000, 1, 6,  32'hDEADBEEF, 32'h0};
        vecs[5]  = '{32'hFE52AC23, 32'h00000114, 0, 5'd0, 32'h0,        32'hFFFFFFF8, 0, 24, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6]  = '{32'h001000EF, 32'h00000118, 0, 5'd0, 32'h0,        32'h00000800, 1, 1,  32'h0,        32'h0};
        vecs[7]  = '{32'hFFDFF06F, 32'h0000011C, 0, 5'd0, 32'h0,        32'hFFFFFFFC, 0, 0,  32'h0,        32'h0};
        vecs[8]  = '{32'h80000397, 32'h00000120, 0, 5'd0, 32'h0,        32'h80000000, 1, 7,  32'h0,        32'h0};
        vecs[9]  = '{32'h000001FF, 32'h00000124, 0, 5'd0, 32'h0,        32'h00000000, 0, 3,  32'h0,        32'h0};
        vecs[10] = '{32'h0042A203, 32'h00000128, 0, 5'd0, 32'h0,        32'h00000004, 1, 4,  32'hDEADBEEF, 32'h0};
        vecs[11] = '{32'h009005B3, 32'h0000012C, 1, 5'd9, 32'hA5A5A5A5, 32'h00000000, 1, 11, 32'h0,        32'hA5A5A5A5};
        vecs[12] = '{32'h00000033, 32'h00000130, 1, 5'd0, 32'h00000001, 32'h00000000, 0, 0,  32'h0,        32'h0};
        vecs[13] = '{32'h00000033, 32'h00000134, 0, 5'd0, 32'h0,        32'h00000000, 0, 0,  32'h0,        32'h0};

        quiet();
        reset = 1'b1; iw_in = 32'h0; pc_in = 32'h0;
        step();
        step();
        chk_bubble("reset");

        // Every register reads zero after reset.
        reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            iw_in = {7'd0, i[4:0], i[4:0], 3'd0, 5'd0, 7'h33};
            step();
            chk($sformatf("rst_x%0d.rs1d", i), rs1_data, 32'h0);
            chk($sformatf("rst_x%0d.rs2d", i), rs2_data, 32'h0);
        end

        for (int v = 0; v < 14; v++) begin
            iw_in = vecs[v].iw; pc_in = vecs[v].pc;
            wb_enable = vecs[v].we; wb_reg = vecs[v].wreg; wb_data = vecs[v].wdata;
            step();
            chk($sformatf("v%0d.iw", v),   iw_out, vecs[v].iw);
            chk($sformatf("v%0d.pc", v),   pc_out, vecs[v].pc);
            chk($sformatf("v%0d.rs1r", v), {27'd0, rs1_reg}, {27'd0, vecs[v].iw[19:15]});
            chk($sformatf("v%0d.rs2r", v), {27'd0, rs2_reg}, {27'd0, vecs[v].iw[24:20]});
            chk($sformatf("v%0d.rd", v),   {27'd0, rd_reg}, {27'd0, vecs[v].rd});
            chk($sformatf("v%0d.imm", v),  imm_out, vecs[v].imm);
            chk($sformatf("v%0d.wbe", v),  {31'd0, wb_enable_out}, {31'd0, vecs[v].wbe});
            chk($sformatf("v%0d.rs1d", v), rs1_data, vecs[v].r1);
            chk($sformatf("v%0d.rs2d", v), rs2_data, vecs[v].r2);
        end
        quiet();

        // Stall: outputs frozen while inputs change and a writeback lands.
        iw_in = 32'h00528133; pc_in = 32'h00000200;
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iw_in = 32'hFFF00093 + k; pc_in = 32'h00000300 + k;
            wb_enable = (k == 0); wb_reg = 5'd7; wb_data = 32'h00000077;
            step();
            chk($sformatf("stall%0d.iw", k),   iw_out, 32'h00528133);
            chk($sformatf("stall%0d.pc", k),   pc_out, 32'h00000200);
            chk($sformatf("stall%0d.rs1d", k), rs1_data, 32'hDEADBEEF);
            chk($sformatf("stall%0d.imm", k),  imm_out, 32'h0);
        end
        quiet();
        iw_in = 32'h00038433; pc_in = 32'h00000204;
        step();
        chk("unstall.iw",   iw_out, 32'h00038433);
        chk("unstall.rs1d", rs1_data, 32'h00000077);
        chk("unstall.rd",   {27'd0, rd_reg}, 32'd8);

        // Flush wins over stall; writeback still commits during the bubble.
        stall = 1'b1; flush = 1'b1;
        wb_enable = 1'b1; wb_reg = 5'd12; wb_data = 32'h00000012;
        step();
        chk_bubble("flush");
        quiet();
        iw_in = 32'h00060033; pc_in = 32'h00000208;
        step();
        chk("postflush.rs1d", rs1_data, 32'h00000012);

        // Reset overrides a concurrent writeback and clears earlier writes.
        reset = 1'b1; wb_enable = 1'b1; wb_reg = 5'd3; wb_data = 32'h5;
        iw_in = 32'h00528133; pc_in = 32'h00000400;
        step();
        chk_bubble("rst_wb");
        quiet();
        iw_in = 32'h00518033; pc_in = 32'h00000404;
        step();
        chk("rst_wb.x3", rs1_data, 32'h0);
        chk("rst_wb.x5", rs2_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv32i_idtop.md
# rv32i_idTop

Instruction-decode stage of the RV32I pipeline, directly downstream of the fetch stage. Each cycle it accepts an instruction word and its PC, reads the two source registers from a 32×32 register file, generates the sign-extended immediate, and registers everything into the ID/EX pipeline register. It also hosts the register-file write port driven by writeback, with same-cycle write-to-read bypass. Stall and flush controls from later stages hold or bubble the pipeline register.

## Interface
Parameters:
- NOP_IW, 32'h00000013, instruction word substituted on reset and flush (`addi x0,x0,0`)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iw_in  in  32  instruction word from fetch
- pc_in  in  32  PC of iw_in, from fetch
- stall  in  1  hold the ID/EX register contents
- flush  in  1  load a bubble into the ID/EX register
- wb_enable  in  1  register-file write strobe from writeback
- wb_reg  in  5  destination register index for the writeback
- wb_data  in  32  writeback data
- iw_out  out  32  registered instruction word
- pc_out  out  32  registered PC
- rs1_reg, rs2_reg, rd_reg  out  5 each  registered iw[19:15], iw[24:20], iw[11:7]
- rs1_data, rs2_data  out  32 each  registered source operand values
- imm_out  out  32  registered sign-extended immediate
- wb_enable_out  out  1  registered flag: the instruction writes rd, and rd≠0

## Operation
- Opcode iw[6:0] selects the immediate format:
  - I: LOAD, OP-IMM, JALR
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - R-type and unknown opcodes: imm = 0
- Immediates are built per the RV32I base spec; bit 31 of iw is always the sign bit. B and J immediates have bit 0 = 0.
- wb_enable_out = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd≠0. It is 0 for all other opcodes.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Writes are committed at the clock edge when wb_enable = 1.
- Bypass: when wb_enable = 1, wb_reg = rsN, and rsN ≠ 0, rsN_data captures wb_data in that same edge instead of the stale array value.
- Pipeline register update at each edge, in priority order:
  - reset: all outputs 0 except iw_out = NOP_IW; all 32 registers cleared to 0.
  - flush: iw_out = NOP_IW, pc_out = 0, every other output 0.
  - stall: every output holds its value.
  - otherwise: load the decoded values of iw_in/pc_in.
- Writeback is independent of stall and flush: a valid wb_enable always commits, except under reset.
- Reset asserted mid-operation takes effect at the next edge and overrides any concurrent writeback.
- flush and stall together: flush wins.

## Timing
- Latency: 1 cycle. iw_in/pc_in sampled at edge N appear on all outputs after edge N.
- Throughput: one instruction per cycle when stall = 0.
- Register-file read is combinational from the array plus bypass mux. Only the ID/EX outputs are registered.
- A write at edge N is visible to an array read from then on. The bypass covers the instruction captured at edge N itself.
- During stall, the register file keeps updating. Held rsN_data is not refreshed; refreshing it is the hazard unit's responsibility.
- No combinational path from any input to any output.

## Structure
- Shared package rv32i_pkg:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG)
  - NOP_IW constant
  - imm-format enum typedef (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE)
- Sub-module rv32i_regFile:
  - 32×32 array, two combinational read ports, one synchronous write port, synchronous clear on reset, x0 forced 0.
  - The bypass mux lives in rv32i_idTop.

## Test plan
- Reset, then idle: all outputs 0, iw_out = 32'h00000013; reading x1..x31 yields 0.
- Writeback x5 = 32'hDEADBEEF at edge N, and iw_in = 32'h00528133 (add x2,x5,x5) at the same edge N -> rs1_data = rs2_data = 32'hDEADBEEF via bypass, rd_reg = 2, wb_enable_out = 1.
- Immediate formats:
  - iw 32'hFFF00093 (addi x1,x0,-1) -> imm_out = 32'hFFFFFFFF
  - iw 32'hFE000EE3 (beq x0,x0,-4) -> imm_out = 32'hFFFFFFFC
  - iw 32'h123450B7 (lui) -> imm_out = 32'h12345000
- Write to x0 with wb_data = 32'h1, then decode an instruction reading x0 -> rs1_data = 0. Decode add x0,… -> wb_enable_out = 0.
- Stall for 3 cycles while iw_in changes -> outputs frozen. A writeback to x7 during the stall is visible after release. flush + stall together -> NOP_IW, pc_out = 0.
- Reset asserted on the same edge as wb_enable for x3 = 5 -> x3 reads 0 afterwards, outputs at reset values.
